arb4_rr_1705: RTL and testbench

- Round-robin channel arbiter that sits directly upstream of the 16-entry request FIFO and drives its arbitration inputs (p_arb_val, p_arb_ch).
- Snoops the same enqueue stream the FIFO sees (p_req_val/p_req_ch) to keep per-channel and total occupancy counts.
- Issues one channel grant per cycle to dequeue the oldest request of that channel, subject to an outstanding-grant credit limit.
- Drives p_req_rdy back-pressure so the FIFO never overflows.

---
 rtl/noc_arb_pkg.sv | 32 +++
 rtl/arb4_rr_pick.sv | 24 ++
 rtl/arb4_rr_1705.sv | 133 +++++++++++++
 tb/tb_arb4_rr_1705.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | noc_arb_pkg : shared constants and rotate-priority helper             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package noc_arb_pkg;

    localparam int NCH   = 4;
    localparam int CH_W  = 2;
    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    // Returns {found, ch}; offsets are walked from far to near so the
    // channel immediately after ptr overrides everything else.
    function automatic logic [CH_W:0] rr_pick(
        input logic [NCH-1:0]  eligible,
        input logic [CH_W-1:0] ptr
    );
        logic [CH_W-1:0] idx;
        logic [CH_W:0]   res;
        res = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = ptr + CH_W'(i);
            if (eligible[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb4_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb4_rr_pick : combinational rotate-priority encoder                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arb4_rr_pick
    import noc_arb_pkg::*;
(
    input  logic [NCH-1:0]  eligible,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] ch
);

    logic [CH_W:0] w_pick;

    always_comb begin
        w_pick = rr_pick(eligible, ptr);
        found  = w_pick[CH_W];
        ch     = w_pick[CH_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/arb4_rr_1705.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb4_rr_1705 : credit-limited round-robin grant generator that        |
// | tracks request-FIFO occupancy per channel and drives back-pressure.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module arb4_rr_1705
    import noc_arb_pkg::*;
#(
    parameter int MAX_OUT = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p_req_val,
    input  logic [CH_W-1:0]      p_req_ch,
    input  logic                 p_done,
    input  logic                 p_en,
    output logic                 p_req_rdy,
    output logic                 p_arb_val,
    output logic [CH_W-1:0]      p_arb_ch,
    output logic [NCH*CNT_W-1:0] p_pend
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] r_cnt     [NCH];
    logic [CNT_W-1:0] w_cnt_nxt [NCH];
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] w_total_nxt;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] w_out_nxt;
    logic [CH_W-1:0]  r_rr_ptr;
    logic             r_arb_val;
    logic [CH_W-1:0]  r_arb_ch;

    logic [NCH-1:0]   w_elig;
    logic [NCH-1:0]   w_inc;
    logic [NCH-1:0]   w_dec;
    logic             w_found;
    logic [CH_W-1:0]  w_win;
    logic             w_credit;
    logic             w_grant;
    logic             w_enq;
    logic             w_done;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            assign w_elig[i] = |r_cnt[i];
            assign w_inc[i]  = w_enq   & (p_req_ch == CH_W'(i));
            assign w_dec[i]  = w_grant & (w_win    == CH_W'(i));
            assign p_pend[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    endgenerate

    arb4_rr_pick u_pick (
        .eligible (w_elig),
        .ptr      (r_rr_ptr),
        .found    (w_found),
        .ch       (w_win)
    );

    // Credit is judged on the registered count, so a same-cycle p_done
    // never unlocks a grant.
    assign w_credit  = (r_out < OUT_W'(MAX_OUT));
    assign w_grant   = p_en & w_found & w_credit;
    assign p_req_rdy = (r_total < CNT_W'(DEPTH));
    assign w_enq     = p_req_val & p_req_rdy;
    assign w_done    = p_done & (r_out != '0);

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            case ({w_inc[i], w_dec[i]})
                2'b10:   w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                2'b01:   w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                default: w_cnt_nxt[i] = r_cnt[i];
            endcase
        end

        w_total_nxt = r_total;
        case ({w_enq, w_grant})
            2'b10:   w_total_nxt = r_total + CNT_W'(1);
            2'b01:   w_total_nxt = r_total - CNT_W'(1);
            default: w_total_nxt = r_total;
        endcase

        w_out_nxt = r_out;
        case ({w_grant, w_done})
            2'b10:   w_out_nxt = r_out + OUT_W'(1);
            2'b01:   w_out_nxt = r_out - OUT_W'(1);
            default: w_out_nxt = r_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_total   <= '0;
            r_out     <= '0;
            r_rr_ptr  <= CH_W'(NCH - 1);
            r_arb_val <= 1'b0;
            r_arb_ch  <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_total   <= w_total_nxt;
            r_out     <= w_out_nxt;
            r_arb_val <= w_grant;
            if (w_grant) begin
                r_rr_ptr <= w_win;
                r_arb_ch <= w_win;
            end
        end
    end

    assign p_arb_val = r_arb_val;
    assign p_arb_ch  = r_arb_ch;

`ifndef SYNTHESIS
    // Upstream protocol errors: enqueue into a full FIFO, or a completion
    // with nothing outstanding.
    a_enq_when_full: assert property (@(posedge clk) disable iff (!rst)
        p_req_val |-> p_req_rdy);
    a_done_underflow: assert property (@(posedge clk) disable iff (!rst)
        p_done |-> (r_out != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_arb4_rr_1705.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_arb4_rr_1705 : scoreboard bench for the round-robin arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_arb4_rr_1705;
    import noc_arb_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 p_req_val;
    logic [CH_W-1:0]      p_req_ch;
    logic                 p_done;
    logic                 p_en;
    logic                 p_req_rdy;
    logic                 p_arb_val;
    logic [CH_W-1:0]      p_arb_ch;
    logic [NCH*CNT_W-1:0] p_pend;

    int              n_cmp = 0;
    int              n_mis = 0;
    logic [CH_W-1:0] exp_q [$];
    bit              auto_done = 1'b0;

    arb4_rr_1705 #(.MAX_OUT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .p_req_val (p_req_val),
        .p_req_ch  (p_req_ch),
        .p_done    (p_done),
        .p_en      (p_en),
        .p_req_rdy (p_req_rdy),
        .p_arb_val (p_arb_val),
        .p_arb_ch  (p_arb_ch),
        .p_pend    (p_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream model: completes each grant in the cycle it is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_done) p_done = p_arb_val;
        end
    end

    task automatic do_reset();
        auto_done = 1'b0;
        p_done    = 1'b0;
        p_req_val = 1'b0;
        p_req_ch  = '0;
        p_en      = 1'b0;
        exp_q.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; p_req_val = 1'b0; p_req_ch = '0; p_done = 1'b0; p_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({p_arb_val, p_arb_ch, p_req_rdy, p_pend} !== {1'b0, 2'd0, 1'b1, 20'd0}) begin
            n_mis++;
            $display("FAIL reset_state: got val=%b ch=%0d rdy=%b pend=%h, required val=0 ch=0 rdy=1 pend=0",
                     p_arb_val, p_arb_ch, p_req_rdy, p_pend);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({p_arb_val, p_req_rdy, p_pend} !== {1'b0, 1'b1, 20'd0}) begin
            n_mis++;
            $display("FAIL reset_release: got val=%b rdy=%b pend=%h, required val=0 rdy=1 pend=0",
                     p_arb_val, p_req_rdy, p_pend);
        end
    endtask

    task automatic test_idle();
        do_reset();
        p_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({p_arb_val, p_req_rdy, p_pend} !== {1'b0, 1'b1, 20'd0}) begin
                n_mis++;
                $display("FAIL idle_c%0d: got val=%b rdy=%b pend=%h, required val=0 rdy=1 pend=0",
                         c, p_arb_val, p_req_rdy, p_pend);
            end
        end
    endtask

    task automatic test_basic();
        logic [CH_W-1:0] seq [3];
        logic [CH_W-1:0] exp_ch;
        seq = '{2'd1, 2'd0, 2'd1};
        do_reset();
        for (int c = 0; c < 3; c++) begin
            p_req_val = 1'b1; p_req_ch = seq[c];
            @(negedge clk);
        end
        p_req_val = 1'b0;
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        p_en = 1'b1; auto_done = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (p_arb_val === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL basic_grant: got ch%0d, required no grant", p_arb_ch);
                end else begin
                    exp_ch = exp_q.pop_front();
                    if (p_arb_ch !== exp_ch) begin
                        n_mis++;
                        $display("FAIL basic_grant: got ch%0d, required ch%0d", p_arb_ch, exp_ch);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || p_pend !== 20'd0) begin
            n_mis++;
            $display("FAIL basic_drain: got %0d grants missing pend=%h, required 0 missing pend=0",
                     exp_q.size(), p_pend);
        end
    endtask

    task automatic test_credit();
        logic [CH_W-1:0] exp_ch;
        do_reset();
        p_en = 1'b1;
        exp_q.push_back(2'd2); exp_q.push_back(2'd2);
        for (int c = 0; c < 10; c++) begin
            p_req_val = (c < 4); p_req_ch = 2'd2;
            @(negedge clk);
            if (p_arb_val === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL credit_grant: got ch%0d, required no grant", p_arb_ch);
                end else begin
                    exp_ch = exp_q.pop_front();
                    if (p_arb_ch !== exp_ch) begin
                        n_mis++;
                        $display("FAIL credit_grant: got ch%0d, required ch%0d", p_arb_ch, exp_ch);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || p_pend[2*CNT_W +: CNT_W] !== 5'd2) begin
            n_mis++;
            $display("FAIL credit_limit: got %0d grants missing pend2=%0d, required 0 missing pend2=2",
                     exp_q.size(), p_pend[2*CNT_W +: CNT_W]);
        end
        p_done = 1'b1;
        @(negedge clk);
        p_done = 1'b0;
        n_cmp++;
        if (p_arb_val !== 1'b0) begin
            n_mis++;
            $display("FAIL credit_same_cycle: got val=%b, required val=0", p_arb_val);
        end
        @(negedge clk);
        n_cmp++;
        if ({p_arb_val, p_arb_ch} !== {1'b1, 2'd2}) begin
            n_mis++;
            $display("FAIL credit_unlock: got val=%b ch=%0d, required val=1 ch=2", p_arb_val, p_arb_ch);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (p_arb_val !== 1'b0) begin
                n_mis++;
                $display("FAIL credit_hold_c%0d: got val=%b, required val=0", c, p_arb_val);
            end
        end
        n_cmp++;
        if (p_pend[2*CNT_W +: CNT_W] !== 5'd1) begin
            n_mis++;
            $display("FAIL credit_pend: got %0d, required 1", p_pend[2*CNT_W +: CNT_W]);
        end
    endtask

    task automatic test_fairness();
        logic [CH_W-1:0] exp_ch;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            p_req_val = 1'b1; p_req_ch = CH_W'(c % 4);
            @(negedge clk);
            exp_q.push_back(CH_W'(c % 4));
        end
        p_req_val = 1'b0;
        p_en = 1'b1; auto_done = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (p_arb_val === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL fair_grant: got ch%0d, required no grant", p_arb_ch);
                end else begin
                    exp_ch = exp_q.pop_front();
                    if (p_arb_ch !== exp_ch) begin
                        n_mis++;
                        $display("FAIL fair_grant: got ch%0d, required ch%0d", p_arb_ch, exp_ch);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || p_pend !== 20'd0) begin
            n_mis++;
            $display("FAIL fair_drain: got %0d grants missing pend=%h, required 0 missing pend=0",
                     exp_q.size(), p_pend);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int c = 0; c < 16; c++) begin
            p_req_val = 1'b1; p_req_ch = 2'd3;
            @(negedge clk);
            if (c == 14) begin
                n_cmp++;
                if (p_req_rdy !== 1'b1) begin
                    n_mis++;
                    $display("FAIL full_at15: got rdy=%b, required rdy=1", p_req_rdy);
                end
            end
        end
        p_req_val = 1'b0;
        n_cmp++;
        if ({p_req_rdy, p_pend[3*CNT_W +: CNT_W]} !== {1'b0, 5'd16}) begin
            n_mis++;
            $display("FAIL full_at16: got rdy=%b pend3=%0d, required rdy=0 pend3=16",
                     p_req_rdy, p_pend[3*CNT_W +: CNT_W]);
        end
        p_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({p_arb_val, p_arb_ch, p_req_rdy, p_pend[3*CNT_W +: CNT_W]} !== {1'b1, 2'd3, 1'b1, 5'd15}) begin
            n_mis++;
            $display("FAIL full_grant: got val=%b ch=%0d rdy=%b pend3=%0d, required val=1 ch=3 rdy=1 pend3=15",
                     p_arb_val, p_arb_ch, p_req_rdy, p_pend[3*CNT_W +: CNT_W]);
        end
        p_req_val = 1'b1; p_req_ch = 2'd3;
        @(negedge clk);
        p_req_val = 1'b0; p_en = 1'b0;
        n_cmp++;
        if ({p_arb_val, p_arb_ch, p_req_rdy, p_pend[3*CNT_W +: CNT_W]} !== {1'b1, 2'd3, 1'b1, 5'd15}) begin
            n_mis++;
            $display("FAIL full_enq_grant: got val=%b ch=%0d rdy=%b pend3=%0d, required val=1 ch=3 rdy=1 pend3=15",
                     p_arb_val, p_arb_ch, p_req_rdy, p_pend[3*CNT_W +: CNT_W]);
        end
        @(negedge clk);
        n_cmp++;
        if ({p_arb_val, p_req_rdy, p_pend[3*CNT_W +: CNT_W]} !== {1'b0, 1'b1, 5'd15}) begin
            n_mis++;
            $display("FAIL full_pulse: got val=%b rdy=%b pend3=%0d, required val=0 rdy=1 pend3=15",
                     p_arb_val, p_req_rdy, p_pend[3*CNT_W +: CNT_W]);
        end
    endtask

    task automatic test_async_reset();
        logic [CH_W-1:0] exp_ch;
        do_reset();
        p_en = 1'b1; auto_done = 1'b1;
        p_req_val = 1'b1; p_req_ch = 2'd2;
        @(negedge clk);
        p_req_ch = 2'd1;
        @(negedge clk);
        p_req_val = 1'b0;
        n_cmp++;
        if ({p_arb_val, p_arb_ch} !== {1'b1, 2'd2}) begin
            n_mis++;
            $display("FAIL arst_pre: got val=%b ch=%0d, required val=1 ch=2", p_arb_val, p_arb_ch);
        end
        #2;
        auto_done = 1'b0; p_done = 1'b0; p_en = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({p_arb_val, p_req_rdy, p_pend} !== {1'b0, 1'b1, 20'd0}) begin
            n_mis++;
            $display("FAIL arst_clear: got val=%b rdy=%b pend=%h, required val=0 rdy=1 pend=0",
                     p_arb_val, p_req_rdy, p_pend);
        end
        #1;
        rst = 1'b1;
        @(negedge clk);
        p_req_val = 1'b1; p_req_ch = 2'd3;
        @(negedge clk);
        p_req_ch = 2'd0;
        @(negedge clk);
        p_req_val = 1'b0;
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        p_en = 1'b1; auto_done = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (p_arb_val === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL arst_grant: got ch%0d, required no grant", p_arb_ch);
                end else begin
                    exp_ch = exp_q.pop_front();
                    if (p_arb_ch !== exp_ch) begin
                        n_mis++;
                        $display("FAIL arst_grant: got ch%0d, required ch%0d", p_arb_ch, exp_ch);
                    end
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || p_pend !== 20'd0) begin
            n_mis++;
            $display("FAIL arst_drain: got %0d grants missing pend=%h, required 0 missing pend=0",
                     exp_q.size(), p_pend);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_credit();
        test_fairness();
        test_full();
        test_async_reset();
        auto_done = 1'b0;
        p_done    = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
